// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg: shared types, constants and address helpers for the data cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 15 - INDEX_W;
  localparam int LINE_W  = 32;
  localparam int HW_W    = 16;

  typedef enum logic [2:0] {
    COMPARE    = 3'd0,
    WB_REQ     = 3'd1,
    WB_WAIT    = 3'd2,
    FILL_REQ   = 3'd3,
    FILL_WAIT  = 3'd4,
    FLUSH_SCAN = 3'd5,
    FLUSH_REQ  = 3'd6,
    FLUSH_WAIT = 3'd7
  } state_e;

  // Line address is the halfword address without its halfword-select bit.
  function automatic logic [14:0] line_addr(input logic [15:0] addr);
    return addr[15:1];
  endfunction

  function automatic logic hw_sel(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
// dcache_array: tag/valid/dirty/data storage, one combinational read port and
// one write port (halfword write, full-line fill, dirty clear). Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 15 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic               we_hw_i,
  input  logic               hw_sel_i,
  input  logic [15:0]        hw_data_i,
  input  logic               we_line_i,
  input  logic [TAG_W-1:0]   line_tag_i,
  input  logic [31:0]        line_data_i,
  input  logic               clr_dirty_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [31:0]        data_o
);

  import dcache_pkg::*;

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem_q  [LINES];
  logic [LINE_W-1:0] data_mem_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_mem_q[idx_i];
  assign data_o  = data_mem_q[idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_line_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (we_hw_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we_line_i) begin
      tag_mem_q[idx_i]  <= line_tag_i;
      data_mem_q[idx_i] <= line_data_i;
    end else if (we_hw_i) begin
      if (hw_sel_i) data_mem_q[idx_i][LINE_W-1:HW_W] <= hw_data_i;
      else          data_mem_q[idx_i][HW_W-1:0]      <= hw_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl: direct-mapped write-back data cache controller with flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        flush_done,
  output logic [14:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rdy
);

  localparam int TAG_W = 15 - INDEX_W;

  import dcache_pkg::*;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] scan_q, scan_d;

  logic [14:0]        w_line;
  logic [INDEX_W-1:0] w_cpu_idx;
  logic [TAG_W-1:0]   w_cpu_tag;
  logic               w_hsel;
  logic               w_flushing;
  logic [INDEX_W-1:0] w_idx;
  logic               w_last;
  logic               w_hit;
  logic               w_req;

  logic               w_valid, w_dirty;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_data;
  logic               w_we_hw, w_we_line, w_clr_dirty;

  assign w_line     = line_addr(cpu_addr);
  assign w_cpu_idx  = w_line[INDEX_W-1:0];
  assign w_cpu_tag  = w_line[14:INDEX_W];
  assign w_hsel     = hw_sel(cpu_addr);
  assign w_flushing = (state_q == FLUSH_SCAN) || (state_q == FLUSH_REQ) ||
                      (state_q == FLUSH_WAIT);
  // During a flush the array is addressed by the scan counter, not the CPU.
  assign w_idx      = w_flushing ? scan_q : w_cpu_idx;
  assign w_last     = (scan_q == {INDEX_W{1'b1}});
  assign w_hit      = w_valid && (w_tag == w_cpu_tag);
  assign w_req      = cpu_re || cpu_we;
  assign cpu_rdata  = w_hsel ? w_data[31:16] : w_data[15:0];

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (w_idx),
    .we_hw_i     (w_we_hw),
    .hw_sel_i    (w_hsel),
    .hw_data_i   (cpu_wdata),
    .we_line_i   (w_we_line),
    .line_tag_i  (w_cpu_tag),
    .line_data_i (mem_rd_data),
    .clr_dirty_i (w_clr_dirty),
    .valid_o     (w_valid),
    .dirty_o     (w_dirty),
    .tag_o       (w_tag),
    .data_o      (w_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COMPARE;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    cpu_stall   = 1'b1;
    flush_done  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {w_tag, w_idx};
    mem_wdata   = w_data;
    w_we_hw     = 1'b0;
    w_we_line   = 1'b0;
    w_clr_dirty = 1'b0;

    case (state_q)
      COMPARE: begin
        if (w_req) begin
          if (w_hit) begin
            cpu_stall = 1'b0;
            w_we_hw   = cpu_we;
          end else if (w_valid && w_dirty) begin
            state_d = WB_REQ;
          end else begin
            state_d = FILL_REQ;
          end
        end else if (flush) begin
          scan_d  = '0;
          state_d = FLUSH_SCAN;
        end else begin
          cpu_stall = 1'b0;
        end
      end
      WB_REQ: begin
        mem_we  = 1'b1;
        state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_rdy) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        mem_re   = 1'b1;
        mem_addr = w_line;
        state_d  = FILL_WAIT;
      end
      FILL_WAIT: begin
        mem_addr = w_line;
        if (mem_rdy) begin
          w_we_line = 1'b1;
          state_d   = COMPARE;
        end
      end
      FLUSH_SCAN: begin
        if (w_valid && w_dirty) begin
          state_d = FLUSH_REQ;
        end else if (w_last) begin
          flush_done = 1'b1;
          scan_d     = '0;
          state_d    = COMPARE;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      FLUSH_REQ: begin
        mem_we  = 1'b1;
        state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (mem_rdy) begin
          w_clr_dirty = 1'b1;
          if (w_last) begin
            flush_done = 1'b1;
            scan_d     = '0;
            state_d    = COMPARE;
          end else begin
            scan_d  = scan_q + 1'b1;
            state_d = FLUSH_SCAN;
          end
        end
      end
      default: state_d = COMPARE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// tb_dcache_ctrl: directed self-checking bench with a 4-wait-cycle memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rd_data;
  logic        mem_rdy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:32767];
  int          mcnt = 0;
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          both_cnt = 0;
  logic [14:0] last_re_addr = '0;
  logic [14:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  dcache_ctrl #(.INDEX_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr    (cpu_addr),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .flush       (flush),
    .flush_done  (flush_done),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rd_data (mem_rd_data),
    .mem_rdy     (mem_rdy)
  );

  always #5 clk = ~clk;

  // Memory contents: low halfword = line^0x5000, high halfword = line^0xA000.
  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = {i[15:0] ^ 16'hA000, i[15:0] ^ 16'h5000};
    end
  end

  assign mem_rdy     = (mcnt == 4);
  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
    end else begin
      if (mem_re && mem_we) both_cnt <= both_cnt + 1;
      if (mem_re || mem_we) begin
        mcnt <= 1;
        if (mem_re) begin
          re_cnt       <= re_cnt + 1;
          last_re_addr <= mem_addr;
        end
        if (mem_we) begin
          we_cnt        <= we_cnt + 1;
          last_we_addr  <= mem_addr;
          last_we_data  <= mem_wdata;
          mem[mem_addr] <= mem_wdata;
        end
      end else if (mcnt == 4) begin
        mcnt <= 0;
      end else if (mcnt != 0) begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic cpu_access(input logic [15:0] a, input logic re, input logic we,
                            input logic [15:0] wd, output int stalls,
                            output logic [15:0] rd);
    @(posedge clk); #1;
    cpu_addr  = a;
    cpu_re    = re;
    cpu_we    = we;
    cpu_wdata = wd;
    stalls    = 0;
    rd        = '0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) begin
        rd = cpu_rdata;
        break;
      end
      stalls++;
      if (stalls > 40) begin
        total++; bad++;
        $display("FAIL access_timeout addr=%h stalled=%0d cycles, required service", a, stalls);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin bad++;
      $display("FAIL reset_mem got re=%b we=%b required 0 0", mem_re, mem_we); end
    total++; if (flush_done !== 1'b0) begin bad++;
      $display("FAIL reset_flush_done got %b required 0", flush_done); end
    total++; if (cpu_stall !== 1'b0) begin bad++;
      $display("FAIL reset_stall_idle got %b required 0", cpu_stall); end
    cpu_addr = 16'h0042; cpu_re = 1'b1; #1;
    total++; if (cpu_stall !== 1'b1) begin bad++;
      $display("FAIL reset_stall_req got %b required 1", cpu_stall); end
    cpu_re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_clean_miss();
    int s; logic [15:0] d; int r0, w0;
    r0 = re_cnt; w0 = we_cnt;
    cpu_access(16'h0042, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 6) begin bad++;
      $display("FAIL clean_miss_stalls got %0d required 6", s); end
    total++; if (d !== 16'h5021) begin bad++;
      $display("FAIL clean_miss_rdata got %h required 5021", d); end
    total++; if (re_cnt - r0 !== 1 || last_re_addr !== 15'h0021 || we_cnt !== w0) begin bad++;
      $display("FAIL clean_miss_mem got re=%0d addr=%h we=%0d required 1 0021 0",
               re_cnt - r0, last_re_addr, we_cnt - w0); end
  endtask

  task automatic test_write_hit();
    int s; logic [15:0] d; int r0, w0;
    r0 = re_cnt; w0 = we_cnt;
    cpu_access(16'h0043, 1'b0, 1'b1, 16'hBEEF, s, d);
    total++; if (s !== 0) begin bad++;
      $display("FAIL write_hit_stalls got %0d required 0", s); end
    cpu_access(16'h0043, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 0 || d !== 16'hBEEF) begin bad++;
      $display("FAIL write_hit_readback got stalls=%0d data=%h required 0 beef", s, d); end
    cpu_access(16'h0042, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 0 || d !== 16'h5021) begin bad++;
      $display("FAIL write_hit_other_hw got stalls=%0d data=%h required 0 5021", s, d); end
    total++; if (re_cnt !== r0 || we_cnt !== w0) begin bad++;
      $display("FAIL write_hit_no_mem got re=%0d we=%0d required 0 0", re_cnt - r0, we_cnt - w0); end
  endtask

  // 0x00C2 maps to index 0x21 like 0x0042 but with tag 1 (line 0x61).
  task automatic test_dirty_miss();
    int s; logic [15:0] d; int r0, w0;
    r0 = re_cnt; w0 = we_cnt;
    cpu_access(16'h00C2, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 11) begin bad++;
      $display("FAIL dirty_miss_stalls got %0d required 11", s); end
    total++; if (d !== 16'h5061) begin bad++;
      $display("FAIL dirty_miss_rdata got %h required 5061", d); end
    total++; if (we_cnt - w0 !== 1 || last_we_addr !== 15'h0021 || last_we_data !== 32'hBEEF5021) begin bad++;
      $display("FAIL dirty_miss_wb got n=%0d addr=%h data=%h required 1 0021 beef5021",
               we_cnt - w0, last_we_addr, last_we_data); end
    total++; if (re_cnt - r0 !== 1 || last_re_addr !== 15'h0061) begin bad++;
      $display("FAIL dirty_miss_fill got n=%0d addr=%h required 1 0061", re_cnt - r0, last_re_addr); end
    cpu_access(16'h0082, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 6 || d !== 16'h5041) begin bad++;
      $display("FAIL clean_miss2 got stalls=%0d data=%h required 6 5041", s, d); end
    cpu_access(16'h0082, 1'b0, 1'b1, 16'hCAFE, s, d);
    total++; if (s !== 0) begin bad++;
      $display("FAIL write_hit2_stalls got %0d required 0", s); end
  endtask

  task automatic test_rw_same();
    int s; logic [15:0] d;
    cpu_access(16'h00C3, 1'b1, 1'b1, 16'h1234, s, d);
    total++; if (s !== 0) begin bad++;
      $display("FAIL rw_same_stalls got %0d required 0", s); end
    cpu_access(16'h00C3, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (d !== 16'h1234) begin bad++;
      $display("FAIL rw_same_readback got %h required 1234", d); end
  endtask

  task automatic test_flush();
    int k; logic seen; int r0, w0; int s; logic [15:0] d;
    r0 = re_cnt; w0 = we_cnt; k = 0; seen = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    while (k < 200 && !seen) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
      else k++;
    end
    flush = 1'b0;
    total++; if (!seen || k !== 74) begin bad++;
      $display("FAIL flush_latency got seen=%b cycles=%0d required 1 74", seen, k); end
    @(negedge clk);
    total++; if (flush_done !== 1'b0) begin bad++;
      $display("FAIL flush_done_pulse got %b required 0", flush_done); end
    total++; if (we_cnt - w0 !== 2 || re_cnt !== r0) begin bad++;
      $display("FAIL flush_writes got we=%0d re=%0d required 2 0", we_cnt - w0, re_cnt - r0); end
    total++; if (mem[15'h41] !== 32'hA041CAFE || mem[15'h61] !== 32'h12345061) begin bad++;
      $display("FAIL flush_data got %h %h required a041cafe 12345061", mem[15'h41], mem[15'h61]); end
    w0 = we_cnt;
    cpu_access(16'h00C3, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 0 || d !== 16'h1234) begin bad++;
      $display("FAIL flush_valid_kept got stalls=%0d data=%h required 0 1234", s, d); end
    cpu_access(16'h0042, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 6 || we_cnt !== w0) begin bad++;
      $display("FAIL flush_dirty_cleared got stalls=%0d wb=%0d required 6 0", s, we_cnt - w0); end
    cpu_access(16'h0043, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (d !== 16'hBEEF) begin bad++;
      $display("FAIL refetch_wb_data got %h required beef", d); end
  endtask

  task automatic test_reset_mid_fill();
    int s; logic [15:0] d; int r0;
    r0 = re_cnt;
    @(posedge clk); #1; cpu_addr = 16'h0104; cpu_re = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (re_cnt - r0 !== 1) begin bad++;
      $display("FAIL mid_fill_issued got %0d required 1", re_cnt - r0); end
    rst_n = 1'b0; #1;
    total++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b1) begin bad++;
      $display("FAIL mid_fill_abort got re=%b we=%b stall=%b required 0 0 1", mem_re, mem_we, cpu_stall); end
    cpu_re = 1'b0; #1;
    total++; if (cpu_stall !== 1'b0) begin bad++;
      $display("FAIL mid_fill_compare got stall=%b required 0", cpu_stall); end
    @(negedge clk); rst_n = 1'b1;
    cpu_access(16'h0104, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 6 || d !== 16'h5082) begin bad++;
      $display("FAIL mid_fill_remiss got stalls=%0d data=%h required 6 5082", s, d); end
    cpu_access(16'h0043, 1'b1, 1'b0, 16'h0, s, d);
    total++; if (s !== 6 || d !== 16'hBEEF) begin bad++;
      $display("FAIL reset_invalidates got stalls=%0d data=%h required 6 beef", s, d); end
  endtask

  task automatic test_protocol();
    total++; if (both_cnt !== 0) begin bad++;
      $display("FAIL mem_re_we_overlap got %0d required 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_rw_same();
    test_flush();
    test_reset_mid_fill();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
